// File: rtl/pmod_keypad_scanner.sv
// 4x4 matrix keypad scanner for a PMOD port: row strobing, column synchronisation,
// full-frame debounce and a one-entry valid/ready holding register for press events.
module pmod_keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 1200,
    parameter int unsigned DEBOUNCE_SCANS = 8
) (
    input  logic       clk,
    input  logic       reset_i,
    output logic [3:0] row_o,
    input  logic [3:0] col_i,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    input  logic       key_ready_i,
    output logic       pressed_o,
    output logic       overflow_o
);

    localparam int unsigned CntW = $clog2(SCAN_DIV);
    localparam int unsigned StW  = $clog2(DEBOUNCE_SCANS + 1);

    logic [3:0]      col_s1_q, col_s2_q;
    logic [1:0]      row_idx_q;
    logic [CntW-1:0] cnt_q;
    logic [15:0]     frame_q, prev_q, deb_q;
    logic [StW-1:0]  stable_q;
    logic [3:0]      code_q;
    logic            valid_q, pressed_q, overflow_q;

    logic            sample, frame_done, commit, press_event, xfer;
    logic [15:0]     snap_d;
    logic [3:0]      snap_idx;

    assign sample     = (cnt_q == CntW'(SCAN_DIV - 1));
    assign frame_done = sample && (row_idx_q == 2'd3);
    assign xfer       = valid_q && key_ready_i;

    // Snapshot including the row being latched this cycle, so frame completion sees all 16 keys.
    always_comb begin
        snap_d = frame_q;
        if (sample) begin
            snap_d[{row_idx_q, 2'b00} +: 4] = ~col_s2_q;
        end
    end

    always_comb begin
        snap_idx = 4'd0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (snap_d[i]) begin
                snap_idx = i[3:0];
            end
        end
    end

    assign commit      = frame_done && (snap_d == prev_q) && (stable_q == StW'(DEBOUNCE_SCANS - 1));
    assign press_event = commit && (deb_q == 16'd0) && $onehot(snap_d);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            col_s1_q   <= 4'hF;
            col_s2_q   <= 4'hF;
            row_idx_q  <= 2'd0;
            cnt_q      <= '0;
            frame_q    <= 16'd0;
            prev_q     <= 16'd0;
            deb_q      <= 16'd0;
            stable_q   <= '0;
            code_q     <= 4'd0;
            valid_q    <= 1'b0;
            pressed_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            col_s1_q <= col_i;
            col_s2_q <= col_s1_q;

            if (sample) begin
                frame_q   <= snap_d;
                row_idx_q <= row_idx_q + 2'd1;
                cnt_q     <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (frame_done) begin
                if (snap_d != prev_q) begin
                    prev_q   <= snap_d;
                    stable_q <= '0;
                end else if (stable_q < StW'(DEBOUNCE_SCANS)) begin
                    stable_q <= stable_q + 1'b1;
                end
            end

            if (commit) begin
                deb_q     <= snap_d;
                pressed_q <= (snap_d != 16'd0);
            end

            // A transfer frees the slot in the same cycle, so a coincident event is not lost.
            if (press_event) begin
                if (valid_q && !key_ready_i) begin
                    overflow_q <= 1'b1;
                end else begin
                    code_q  <= snap_idx;
                    valid_q <= 1'b1;
                end
            end else if (xfer) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign row_o       = ~(4'b0001 << row_idx_q);
    assign key_code_o  = code_q;
    assign key_valid_o = valid_q;
    assign pressed_o   = pressed_q;
    assign overflow_o  = overflow_q;

endmodule
